// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - valid/ready request and response channels between CPU and mem_responder
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory target with fixed access latency
// Optional TEXT_WRITE_PROTECT_EN: stores into the first TEXT_WORDS words fault instead of writing.
module mem_responder #(
    parameter int DEPTH      = 4096,
    parameter int LATENCY    = 3,
    parameter int TEXT_WORDS = 2048
) (
    input  logic            i_clk,
    input  logic            i_reset,
    mem_responder_if.slave  bus
);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (LATENCY < 1 || LATENCY > 15 || TEXT_WORDS > DEPTH) begin : g_bad_param
        $error("mem_responder: illegal LATENCY or TEXT_WORDS");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_we;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic [3:0]      w_be;
    logic            w_prot;
    logic            w_err;
    logic            w_commit;
    logic [IDXW-1:0] w_idx;

    // With LATENCY==1 the request enters RESP on its accept edge, so use the live inputs then.
    always_comb begin
        w_we    = r_we;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_be    = r_be;
        if (r_state == S_IDLE) begin
            w_we    = bus.req_we;
            w_addr  = bus.req_addr;
            w_wdata = bus.req_wdata;
            w_be    = bus.req_be;
        end
    end

`ifdef TEXT_WRITE_PROTECT_EN
    assign w_prot = w_we && (w_addr[31:2] < 30'(TEXT_WORDS));
`else
    assign w_prot = 1'b0;
`endif

    assign w_idx    = w_addr[IDXW+1:2];
    assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= 30'(DEPTH)) || w_prot;
    assign w_commit = w_enter_resp && w_we && !w_err && i_reset;

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_next       = S_RESP;
                        w_enter_resp = 1'b1;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_be    <= bus.req_be;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Array is never reset; contents survive reset and change only through stores.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed scoreboard bench for mem_responder
module tb_mem_responder;
    localparam int DEPTH      = 4096;
    localparam int LAT        = 3;
    localparam int TEXT_WORDS = 2048;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .TEXT_WORDS(TEXT_WORDS)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    bit   [31:0] model [int];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit push, input bit keep);
        int          n = 0;
        int          idx;
        bit          err;
        bit   [31:0] old;
        exp_t        e;
        @(negedge clk);
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 50), 32'd1);
        idx = int'(addr >> 2);
        err = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
`ifdef TEXT_WRITE_PROTECT_EN
        if (we && idx < TEXT_WORDS) err = 1'b1;
`endif
        if (push) begin
            if (!err && we && (be == 4'hF || model.exists(idx))) begin
                old = model.exists(idx) ? model[idx] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (be[b]) old[8*b +: 8] = wdata[8*b +: 8];
                model[idx] = old;
            end
            e.err   = err;
            e.rdata = (err || we) ? 32'h0 : (model.exists(idx) ? model[idx] : 32'h0);
            e.chk   = err || we || model.exists(idx);
            sb.push_back(e);
        end
        @(posedge clk);
        if (!keep) #1 bus.req_valid = 1'b0;
    endtask

    task automatic recv(input bit ack, input int stall);
        int   lat = 1;
        exp_t e;
        @(negedge clk);
        while (!bus.resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(LAT));
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        e = sb.pop_front();
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 32'(bus.resp_valid), 32'd1);
            check("stall_ready", 32'(bus.req_ready), 32'd0);
            if (e.chk) check("stall_rdata", bus.resp_rdata, e.rdata);
            @(negedge clk);
        end
        check("err", 32'(bus.resp_err), 32'(e.err));
        if (e.chk) check("rdata", bus.resp_rdata, e.rdata);
        if (ack) begin
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.resp_ready = 1'b0;
            bus.req_valid  = 1'b0;
            @(negedge clk);
            check("post_ack_valid", 32'(bus.resp_valid), 32'd0);
            check("post_ack_ready", 32'(bus.req_ready), 32'd1);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
        send(we, addr, wdata, be, 1'b1, 1'b0);
        recv(1'b1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_be     = 4'h0;
        bus.resp_ready = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'h0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_req_ready", 32'(bus.req_ready), 32'd1);
        check("rel_resp_valid", 32'(bus.resp_valid), 32'd0);

        // preload through the store path
        xfer(1'b1, 32'h0000, 32'h20080005, 4'hF);
        xfer(1'b1, 32'h2000, 32'h11223344, 4'hF);
        xfer(1'b1, 32'h2004, 32'hCAFEF00D, 4'hF);
        xfer(1'b1, 32'h0010, 32'h00000055, 4'hF);

        xfer(1'b0, 32'h0000, 32'h0, 4'h0);
        xfer(1'b1, 32'h2000, 32'hDEADBEEF, 4'b0101);
        xfer(1'b0, 32'h2000, 32'h0, 4'h0);

        // response stall with req_valid held high
        send(1'b0, 32'h2004, 32'h0, 4'h0, 1'b1, 1'b1);
        recv(1'b1, 5);

        xfer(1'b1, 32'h2000, 32'hFFFFFFFF, 4'h0);
        xfer(1'b0, 32'h2000, 32'h0, 4'h0);

        xfer(1'b0, 32'h2002, 32'h0, 4'h0);
        xfer(1'b0, 32'(4 * DEPTH), 32'h0, 4'h0);
        xfer(1'b1, 32'h2006, 32'h0, 4'hF);
        xfer(1'b0, 32'h2004, 32'h0, 4'h0);

        // reset while a store waits: must not commit
        send(1'b1, 32'h2004, 32'h12345678, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("wait_rst_valid", 32'(bus.resp_valid), 32'd0);
        check("wait_rst_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h2004, 32'h0, 4'h0);

        // reset while a committed store sits in RESP: data stays
        send(1'b1, 32'h2008, 32'h0BADCAFE, 4'hF, 1'b1, 1'b0);
        recv(1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("resp_rst_valid", 32'(bus.resp_valid), 32'd0);
        check("resp_rst_rdata", bus.resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h2008, 32'h0, 4'h0);

        xfer(1'b1, 32'h0010, 32'h00000000, 4'hF);
        xfer(1'b0, 32'h0010, 32'h0, 4'h0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Word-addressed memory target that answers load/store requests issued by the multi-cycle CPU over a valid/ready request channel and a valid/ready response channel. Access latency is configurable, so benches exercise the CPU's memory wait states rather than zero-latency combinational memory. Sits between the CPU core and the backing array. The array is loadable by $readmemh at word offset 0 for .text and word offset 2048 for .data.

Parameters:
DEPTH, 4096, number of 32-bit words in the array (byte space 0 .. 4*DEPTH-1)
LATENCY, 3, cycles from request accept to resp_valid; legal range 1..15
TEXT_WORDS, 2048, words of .text segment starting at word 0; used only by the optional feature

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; low clears all control state immediately
req_valid  input  1  CPU presents a request
req_ready  output  1  responder can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables for stores; bit i gates byte [8i+7:8i]
resp_valid  output  1  response available
resp_ready  input  1  CPU consumes response
resp_rdata  output  32  load data (0 for stores and errors)
resp_err  output  1  request faulted

Behaviour:
- Reset (reset low, async): state=IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not cleared.
- States:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready at edge N; latch we/addr/wdata/be. Go to WAIT with counter=LATENCY-1. If LATENCY==1, go directly to RESP.
  - WAIT: counter decrements each edge; at 1 -> RESP.
  - RESP: resp_valid=1 first at cycle N+LATENCY; outputs held stable until resp_valid&&resp_ready, then -> IDLE (req_ready=1 next cycle).
- Throughput: one outstanding request; back-to-back period = LATENCY+1 cycles minimum with resp_ready tied high.
- Error: resp_err=1 if addr[1:0]!=0 or addr>>2 >= DEPTH. No array write occurs; resp_rdata=0. Error responses still take the full LATENCY.
- Load: resp_rdata = mem[addr>>2], sampled on the transition into RESP.
- Store: commits on the transition into RESP, only enabled bytes change; be=0 is a legal no-op. resp_rdata=0.
- Reset mid-operation: pending request is discarded. A store not yet in RESP is never committed. A store already committed stays committed.
- Inputs are ignored outside IDLE; req_valid may stay high across a response without a duplicate accept.
- A load following a store to the same word returns the new data.

Optional Feature:
TEXT_WRITE_PROTECT_EN
- Defined: stores whose word index < TEXT_WORDS are dropped and answered with resp_err=1 at normal latency; loads are unaffected.
- Undefined: .text is writable like any other word; no extra logic.

Test Plan:
- Reset release with LATENCY=3: req_ready=1, resp_valid=0 → load addr 0x0 with mem[0]=0x20080005 accepted at edge N; resp_valid first high at N+3, rdata=0x20080005, err=0.
- Store 0xDEADBEEF be=4'b0101 to 0x2000 (mem[2048]=0x11223344), then load 0x2000 → rdata=0x11AD33EF.
- Hold resp_ready low 5 cycles → resp_valid/rdata stable throughout, req_ready=0, no second accept while req_valid stays high.
- Load 0x2002 (misaligned) and load 4*DEPTH → both give err=1, rdata=0. Array is unchanged.
- Assert reset low during WAIT of a store to 0x2004 → resp_valid drops immediately; later load 0x2004 returns the old value.
- With TEXT_WRITE_PROTECT_EN: store 0x0 to 0x0010 → err=1, mem[4] is unchanged. Without the macro: store succeeds with err=0.
